// File: rtl/mcs4_phase_sequencer.sv
// mcs4_phase_sequencer
// Two-phase clock (clk1/clk2), subcycle (A1..X3) and power-on-clear sequencer
// for the MCS-4 core. All state is on the rising edge of sysclk; rst_n is an
// asynchronous active-low reset.
//
// Optional feature macro: MCS4_SINGLE_STEP_EN
//   defined   -> STEP state present, step_req rising edge runs one instruction
//                cycle from IDLE and step_done pulses when it ends.
//   undefined -> STEP state not built, step_req ignored, step_done tied low.
//
// Outputs are registered decodes of the state/counters, so they trail the
// internal counters by one sysclk: the edge that leaves IDLE is followed one
// edge later by running=1 and the first clk1 tick of A1.
module mcs4_phase_sequencer #(
  parameter int PHASE_LEN  = 2,
  parameter int GAP_LEN    = 1,
  parameter int POC_CYCLES = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       poc_req,
  input  logic       step_req,
  output logic       clk1,
  output logic       clk2,
  output logic       sync,
  output logic [2:0] subcycle,
  output logic       poc,
  output logic       running,
  output logic       step_done
);

  // Ticks per subcycle: phase1 pulse, gap, phase2 pulse, gap.
  localparam int         SUB_LEN  = 2 * PHASE_LEN + 2 * GAP_LEN;
  localparam logic [5:0] PH_LAST  = 6'(SUB_LEN - 1);
  localparam logic [5:0] CLK1_END = 6'(PHASE_LEN);
  localparam logic [5:0] CLK2_BEG = 6'(PHASE_LEN + GAP_LEN);
  localparam logic [5:0] CLK2_END = 6'(2 * PHASE_LEN + GAP_LEN);
  localparam logic [3:0] POC_LOAD = 4'(POC_CYCLES);
  localparam logic [2:0] SUB_X3   = 3'd7;

`ifdef MCS4_SINGLE_STEP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  state_t     state_reg;
  logic [5:0] ph_cnt_reg;
  logic [5:0] ph_cnt_next;
  logic [2:0] sub_reg;
  logic [2:0] sub_next;
  logic [3:0] poc_cnt_reg;
  logic [3:0] poc_cnt_next;
  logic       poc_reg;
  logic       poc_next;

  logic       clk1_reg;
  logic       clk2_reg;
  logic       sync_reg;
  logic [2:0] subcycle_reg;
  logic       running_reg;

  logic       active;
  logic       boundary;
  logic       start_run;
  logic       stop_ok;

`ifdef MCS4_SINGLE_STEP_EN
  logic       step_prev_reg;
  logic       step_end_reg;
  logic       step_done_reg;
  logic       step_edge;
`else
  // step_req is kept on the port list for wiring compatibility only.
  logic       unused_step_req;
  assign unused_step_req = step_req;
`endif

  // Next-state terms: counter advance, boundary detect and POC countdown.
  always_comb begin
    active       = (state_reg != IDLE);
    boundary     = active && (ph_cnt_reg == PH_LAST) && (sub_reg == SUB_X3);

    ph_cnt_next  = ph_cnt_reg + 6'd1;
    sub_next     = sub_reg;
    if (ph_cnt_reg == PH_LAST) begin
      ph_cnt_next = 6'd0;
      sub_next    = sub_reg + 3'd1;
    end

    // A held poc_req keeps reloading the count; otherwise count down one
    // per completed instruction cycle and drop poc as it reaches zero.
    poc_cnt_next = poc_cnt_reg;
    poc_next     = poc_reg;
    if (poc_req) begin
      poc_cnt_next = POC_LOAD;
      poc_next     = 1'b1;
    end else if (boundary && (poc_cnt_reg != 4'd0)) begin
      poc_cnt_next = poc_cnt_reg - 4'd1;
      if (poc_cnt_reg == 4'd1) begin
        poc_next = 1'b0;
      end
    end

    // poc must keep clocks running so the 4004 can clear.
    start_run    = run_en || poc_reg;
    // Use the post-edge poc so the cycle that clears poc is the last one.
    stop_ok      = !run_en && !poc_next;
  end

`ifdef MCS4_SINGLE_STEP_EN
  // Rising edge of step_req against its registered copy.
  assign step_edge = step_req && !step_prev_reg;
`endif

  // Sequencer FSM with phase/subcycle counters, POC and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ph_cnt_reg    <= 6'd0;
      sub_reg       <= 3'd0;
      poc_cnt_reg   <= POC_LOAD;
      poc_reg       <= 1'b1;
      clk1_reg      <= 1'b0;
      clk2_reg      <= 1'b0;
      sync_reg      <= 1'b0;
      subcycle_reg  <= 3'd0;
      running_reg   <= 1'b0;
`ifdef MCS4_SINGLE_STEP_EN
      step_prev_reg <= 1'b0;
      step_end_reg  <= 1'b0;
      step_done_reg <= 1'b0;
`endif
    end else begin
      poc_reg       <= poc_next;
      poc_cnt_reg   <= poc_cnt_next;

      // Output decode of the tick currently held in the counters.
      clk1_reg      <= active && (ph_cnt_reg < CLK1_END);
      clk2_reg      <= active && (ph_cnt_reg >= CLK2_BEG) && (ph_cnt_reg < CLK2_END);
      sync_reg      <= active && (sub_reg == SUB_X3);
      subcycle_reg  <= active ? sub_reg : 3'd0;
      running_reg   <= active;

`ifdef MCS4_SINGLE_STEP_EN
      step_prev_reg <= step_req;
      step_end_reg  <= 1'b0;
      // step_done lines up with the edge where running falls.
      step_done_reg <= step_end_reg;
`endif

      case (state_reg)
        IDLE: begin
          ph_cnt_reg <= 6'd0;
          sub_reg    <= 3'd0;
          if (start_run) begin
            state_reg <= RUN;
`ifdef MCS4_SINGLE_STEP_EN
          end else if (step_edge) begin
            // start_run is low here, so run_en=0: a step is allowed.
            state_reg <= STEP;
`endif
          end
        end

        RUN: begin
          ph_cnt_reg <= ph_cnt_next;
          sub_reg    <= sub_next;
          if (boundary && stop_ok) begin
            state_reg <= IDLE;
          end
        end

`ifdef MCS4_SINGLE_STEP_EN
        STEP: begin
          ph_cnt_reg <= ph_cnt_next;
          sub_reg    <= sub_next;
          if (boundary) begin
            state_reg    <= IDLE;
            step_end_reg <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg  <= IDLE;
          ph_cnt_reg <= 6'd0;
          sub_reg    <= 3'd0;
        end
      endcase
    end
  end

  assign clk1     = clk1_reg;
  assign clk2     = clk2_reg;
  assign sync     = sync_reg;
  assign subcycle = subcycle_reg;
  assign poc      = poc_reg;
  assign running  = running_reg;

`ifdef MCS4_SINGLE_STEP_EN
  assign step_done = step_done_reg;
`else
  assign step_done = 1'b0;
`endif

endmodule

// File: tb/tb_mcs4_phase_sequencer.sv
// Testbench for mcs4_phase_sequencer (default parameters: 6-tick subcycle,
// 48-tick instruction cycle, 2 POC cycles). A table of {inputs, advance,
// expected outputs} records covers reset release and start/stop latency;
// hand-written sequences cover pulse shape, free-run, mid-cycle stop, poc_req,
// single step (MCS4_SINGLE_STEP_EN) and asynchronous reset.
module tb_mcs4_phase_sequencer;

  logic       sysclk   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       run_en   = 1'b0;
  logic       poc_req  = 1'b0;
  logic       step_req = 1'b0;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic [2:0] subcycle;
  logic       poc;
  logic       running;
  logic       step_done;

  int n_vec = 0;
  int n_err = 0;

  mcs4_phase_sequencer #(
    .PHASE_LEN (2),
    .GAP_LEN   (1),
    .POC_CYCLES(2)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .poc_req  (poc_req),
    .step_req (step_req),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .subcycle (subcycle),
    .poc      (poc),
    .running  (running),
    .step_done(step_done)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       run_en;
    logic       poc_req;
    logic       step_req;
    int         adv;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[19];

  // Counters for the pulse-shape and step sequences.
  int   c1_rise, c2_rise, overlap, bad_width, bad_gap, poc_hi, run_hi;
  int   w1, w2, low_run, sd_cnt, sd_at, act_cnt;
  logic p1, p2, ph, h, seen_fall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  function automatic logic [8:0] pk(input int c1, input int c2, input int sy, input int sb,
                                    input int pc, input int rn, input int sd);
    return {c1[0], c2[0], sy[0], sb[2:0], pc[0], rn[0], sd[0]};
  endfunction

  function automatic logic [8:0] obs();
    return {clk1, clk2, sync, subcycle, poc, running, step_done};
  endfunction

  // Expected {subcycle, sync, clk1, clk2, running} at tick t of a free run.
  function automatic logic [6:0] run_exp(input int t);
    int         tt;
    int         phs;
    logic [2:0] sb;
    tt  = t % 48;
    phs = tt % 6;
    sb  = 3'(tt / 6);
    return {sb, (tt >= 42), (phs < 2), ((phs == 3) || (phs == 4)), 1'b1};
  endfunction

  function automatic logic [6:0] run_obs();
    return {subcycle, sync, clk1, clk2, running};
  endfunction

  task automatic reset_dut();
    rst_n    = 1'b0;
    run_en   = 1'b0;
    poc_req  = 1'b0;
    step_req = 1'b0;
    tick(2);
    check("reset_state", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 0, 0)));
    rst_n = 1'b1;
  endtask

  initial begin
    // {run_en, poc_req, step_req, edges to advance, expected outputs}
    vecs[0]  = '{1'b0, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 1, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0,  1, pk(1, 0, 0, 0, 1, 1, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0,  1, pk(1, 0, 0, 0, 1, 1, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 1, 1, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0,  1, pk(0, 1, 0, 0, 1, 1, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b0,  1, pk(0, 1, 0, 0, 1, 1, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 1, 1, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0,  1, pk(1, 0, 0, 1, 1, 1, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 36, pk(1, 0, 1, 7, 1, 1, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,  5, pk(0, 0, 1, 7, 1, 1, 0)};
    vecs[10] = '{1'b0, 1'b0, 1'b0,  1, pk(1, 0, 0, 0, 1, 1, 0)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 21, pk(0, 1, 0, 3, 1, 1, 0)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 26, pk(0, 0, 1, 7, 0, 1, 0)};
    vecs[13] = '{1'b0, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 0, 0, 0)};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 10, pk(0, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{1'b1, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 0, 0, 0)};
    vecs[16] = '{1'b1, 1'b0, 1'b0,  1, pk(1, 0, 0, 0, 0, 1, 0)};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 47, pk(0, 0, 1, 7, 0, 1, 0)};
    vecs[18] = '{1'b0, 1'b0, 1'b0,  1, pk(0, 0, 0, 0, 0, 0, 0)};

    // ---- Table: reset release, POC run-out, start and stop latency ----
    reset_dut();
    for (int i = 0; i < 19; i++) begin
      run_en   = vecs[i].run_en;
      poc_req  = vecs[i].poc_req;
      step_req = vecs[i].step_req;
      tick(vecs[i].adv);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // ---- Pulse shape across the POC run after reset ----
    reset_dut();
    c1_rise = 0; c2_rise = 0; overlap = 0; bad_width = 0; bad_gap = 0;
    poc_hi = 0; run_hi = 0; w1 = 0; w2 = 0; low_run = 0;
    p1 = 1'b0; p2 = 1'b0; ph = 1'b0; seen_fall = 1'b0;
    for (int e = 1; e <= 110; e++) begin
      tick(1);
      if (clk1 && clk2) overlap++;
      if (clk1 && !p1) c1_rise++;
      if (clk2 && !p2) c2_rise++;
      if (clk1) w1++;
      else begin
        if (p1 && (w1 != 2)) bad_width++;
        w1 = 0;
      end
      if (clk2) w2++;
      else begin
        if (p2 && (w2 != 2)) bad_width++;
        w2 = 0;
      end
      h = clk1 | clk2;
      if (h && !ph && seen_fall && (low_run != 1)) bad_gap++;
      if (!h && ph) seen_fall = 1'b1;
      if (h) low_run = 0;
      else low_run++;
      if (poc) poc_hi++;
      if (running) run_hi++;
      p1 = clk1;
      p2 = clk2;
      ph = h;
    end
    check("poc_clk1_pulses", 32'(c1_rise), 32'd16);
    check("poc_clk2_pulses", 32'(c2_rise), 32'd16);
    check("poc_pulse_width", 32'(bad_width), 32'd0);
    check("poc_pulse_gap", 32'(bad_gap), 32'd0);
    check("poc_overlap", 32'(overlap), 32'd0);
    check("poc_high_ticks", 32'(poc_hi), 32'd96);
    check("poc_running_ticks", 32'(run_hi), 32'd96);

    // ---- Free run: subcycle/sync/phase pattern over two cycles ----
    run_en = 1'b1;
    tick(1);
    for (int t = 0; t < 96; t++) begin
      tick(1);
      check($sformatf("freerun_t%0d", t), 32'(run_obs()), 32'(run_exp(t)));
    end

    // ---- run_en dropped at tick 10 (A2): cycle completes, then IDLE ----
    tick(11);
    check("drop_at_a2", 32'(run_obs()), 32'(run_exp(10)));
    run_en = 1'b0;
    for (int k = 11; k < 48; k++) begin
      tick(1);
      check($sformatf("drain_t%0d", k), 32'(run_obs()), 32'(run_exp(k)));
    end
    tick(1);
    check("drain_stop", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    act_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      tick(1);
      if (clk1 || clk2 || running) act_cnt++;
    end
    check("drain_idle_quiet", 32'(act_cnt), 32'd0);

    // ---- poc_req pulsed in M1: counting undisturbed, clears 2 cycles later ----
    run_en = 1'b1;
    tick(1);
    for (int t = 0; t <= 18; t++) begin
      tick(1);
      check($sformatf("pocreq_pre_t%0d", t), 32'({poc, run_obs()}), 32'({1'b0, run_exp(t)}));
    end
    poc_req = 1'b1;
    run_en  = 1'b0;
    tick(1);
    check("pocreq_rise", 32'({poc, run_obs()}), 32'({1'b1, run_exp(19)}));
    poc_req = 1'b0;
    for (int t = 20; t < 96; t++) begin
      tick(1);
      check($sformatf("pocreq_t%0d", t), 32'({poc, run_obs()}), 32'({(t < 95), run_exp(t)}));
    end
    tick(1);
    check("pocreq_stop", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));

    // ---- Single step from IDLE, with a second step_req edge mid-step ----
    step_req = 1'b1;
    c1_rise = 0; sd_cnt = 0; sd_at = 0; run_hi = 0; p1 = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      tick(1);
      if (j == 5)  step_req = 1'b0;
      if (j == 10) step_req = 1'b1;
      if (j == 20) step_req = 1'b0;
      if (clk1 && !p1) c1_rise++;
      if (step_done) begin
        sd_cnt++;
        sd_at = j;
      end
      if (running) run_hi++;
      p1 = clk1;
    end
`ifdef MCS4_SINGLE_STEP_EN
    check("step_clk1_pulses", 32'(c1_rise), 32'd8);
    check("step_done_count", 32'(sd_cnt), 32'd1);
    check("step_done_edge", 32'(sd_at), 32'd50);
    check("step_running_ticks", 32'(run_hi), 32'd48);
`else
    check("step_clk1_pulses", 32'(c1_rise), 32'd0);
    check("step_done_count", 32'(sd_cnt), 32'd0);
    check("step_done_edge", 32'(sd_at), 32'd0);
    check("step_running_ticks", 32'(run_hi), 32'd0);
`endif
    check("step_end_idle", 32'(running), 32'd0);

    // ---- run_en together with a step_req edge in IDLE: RUN wins ----
    run_en   = 1'b1;
    step_req = 1'b1;
    sd_cnt   = 0;
    for (int j = 1; j <= 81; j++) begin
      tick(1);
      if (step_done) sd_cnt++;
    end
    check("runwins_no_step_done", 32'(sd_cnt), 32'd0);
    check("runwins_x1", 32'(run_obs()), 32'(run_exp(79)));

    // ---- Asynchronous reset in X1 (clk1 high): immediate reset values ----
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 0, 0)));
    tick(1);
    check("async_reset_hold", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 0, 0)));
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcs4_phase_sequencer.md
# mcs4_phase_sequencer

Two-phase clock and subcycle sequencer for the MCS-4 core. It divides `sysclk` into the non-overlapping `clk1`/`clk2` phase pulses consumed by the timing/I/O board and tracks the eight subcycles (A1..X3) of each instruction cycle. It also owns power-on-clear (`poc`) sequencing and the run/stop control, plus optional single-step. It replaces the externally driven `clk1_pad`/`clk2_pad`/`poc_pad` inputs of the top level.

## Interface
Parameters:
- `PHASE_LEN`, 2: `sysclk` cycles each phase pulse stays high (1..15).
- `GAP_LEN`, 1: `sysclk` cycles of non-overlap after each pulse (1..15).
- `POC_CYCLES`, 2: complete instruction cycles `poc` is held after reset or `poc_req` (1..15).

Ports:
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  level; 1 = free-run instruction cycles.
- `poc_req`  in  1  level; synchronous request to re-enter power-on-clear.
- `step_req`  in  1  rising edge requests one instruction cycle from IDLE.
- `clk1`  out  1  phase-1 pulse, registered.
- `clk2`  out  1  phase-2 pulse, registered.
- `sync`  out  1  high for the whole X3 subcycle.
- `subcycle`  out  3  0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- `poc`  out  1  active-high clear to all boards.
- `running`  out  1  1 when the FSM is not IDLE.
- `step_done`  out  1  one-cycle pulse at the end of a stepped instruction cycle.

## Operation
- Subcycle length L = 2·PHASE_LEN + 2·GAP_LEN ticks. `ph_cnt` runs 0..L-1.
  - `clk1` = 1 while `ph_cnt` < PHASE_LEN.
  - `clk2` = 1 while PHASE_LEN+GAP_LEN ≤ `ph_cnt` < 2·PHASE_LEN+GAP_LEN.
  - `clk1` and `clk2` are never high in the same cycle.
- `subcycle` increments when `ph_cnt` wraps at L-1, and wraps from 7 to 0. "Boundary" means the last tick of X3.
- FSM states:
  - IDLE: `ph_cnt`=0, `subcycle`=0, `clk1`=`clk2`=`sync`=0, `running`=0.
  - RUN: free-running.
  - STEP: exactly one instruction cycle.
- Transitions:
  - IDLE→RUN when `run_en`=1 or `poc`=1.
  - IDLE→STEP on a `step_req` rising edge while `run_en`=0.
  - RUN→IDLE at a boundary when `run_en`=0 and `poc`=0.
  - STEP→IDLE at the boundary, with `step_done` pulsed.
- Stopping happens only at a boundary. A cycle that has started always completes.
- Simultaneous `run_en`=1 and `step_req` edge in IDLE: RUN wins, and no `step_done` is produced.
- `step_req` edges are ignored outside IDLE. Edge detection uses a registered copy of `step_req` that is cleared on reset.
- POC:
  - `poc_cnt` (4 bits) is loaded with POC_CYCLES and `poc` is set while `poc_req`=1.
  - With `poc_req`=0, `poc_cnt` decrements at each boundary. `poc` clears on the same edge that the count reaches 0.
  - While `poc`=1 the sequencer runs regardless of `run_en`. The 4004 needs clocks to clear.
- `poc_req` asserted mid-cycle: `poc` goes high on the next edge. The phase/subcycle counters are not disturbed.

## Timing
- Reset values:
  - `clk1`=0, `clk2`=0, `sync`=0, `subcycle`=0, `running`=0, `step_done`=0.
  - `poc`=1, `poc_cnt`=POC_CYCLES, FSM=IDLE.
- The first edge after reset release takes the FSM to RUN because `poc`=1.
- Outputs are registered. If the edge that samples the start condition in IDLE is edge k, then `running`=1 and `clk1`=1 from edge k+1, with `ph_cnt`=0 and `subcycle`=A1.
- Instruction cycle = 8·L ticks; 48 with defaults.
- Stop timing:
  - `running` falls on the edge after the boundary tick.
  - `step_done` is high for exactly that one cycle.
  - `clk1`/`clk2` are 0 from that edge.
- Reset asserted mid-cycle asynchronously forces all reset values immediately. A truncated phase pulse is acceptable only under reset.

## Configuration
- `MCS4_SINGLE_STEP_EN` defined: STEP state present, and `step_req`/`step_done` behave as above.
- `MCS4_SINGLE_STEP_EN` undefined:
  - The STEP state is not compiled.
  - `step_req` is ignored.
  - `step_done` is tied to 0.
  - Ports remain so the top-level wiring is unchanged.

## Test plan
- Reset release with `run_en`=0 and defaults:
  - `poc`=1 for 96 ticks, then 0.
  - `running` falls after the second boundary.
  - 16 `clk1` and 16 `clk2` pulses are seen, each 2 ticks wide with 1-tick gaps.
- `run_en`=1 after POC:
  - `subcycle` steps 0..7 every 6 ticks.
  - `sync` is high for ticks 42..47 of each 48-tick cycle.
  - `clk1`&`clk2` is never 1.
- `run_en` dropped at tick 10 of A2: the cycle completes through X3, then IDLE, with `clk1`/`clk2` held at 0.
- Single step (macro on):
  - A `step_req` edge in IDLE gives exactly 8 `clk1` pulses, then `step_done`=1 for one cycle, then `running`=0.
  - A second edge during STEP is ignored.
- `poc_req` pulsed during M1:
  - `poc`=1 next edge, and subcycle counting is uninterrupted.
  - `poc` clears at the second boundary after `poc_req` falls.
- `rst_n` low mid-X1: all outputs take their reset values immediately, with `poc`=1.
